raster_frame_sequencer: RTL and testbench

- Owns the pixel BRAM write port (port A) and the raster scan counters feeding triangle_2d_fill.
- Per frame: clears the framebuffer to a programmable colour, then accepts projected triangles one at a time via valid/ready. For each triangle it runs one full-screen coverage sweep and writes covered pixels in the triangle's colour.
- Sits between triangle_3d_to_2d / rasterization_controller and pixel_bram. Replaces the free-running hcount/vcount loop and the sw-driven clear mux.

---
 rtl/raster_frame_sequencer_pkg.sv | 19 +
 rtl/raster_frame_sequencer_if.sv | 29 ++
 rtl/pipe.sv | 24 ++
 rtl/raster_scan_counter.sv | 47 ++++
 rtl/raster_frame_sequencer.sv | 141 ++++++++++++++
 tb/tb_raster_frame_sequencer.sv | 242 ++++++++++++++++++++++++
 6 files changed

// File: rtl/raster_frame_sequencer_pkg.sv
// Shared types and default geometry for the raster frame sequencer.
package raster_frame_sequencer_pkg;

  localparam int DEF_FRAME_WIDTH  = 512;
  localparam int DEF_FRAME_HEIGHT = 384;
  localparam int DEF_COORD_BITS   = 16;
  localparam int DEF_ADDR_BITS    = 18;
  localparam int DEF_COLOR_WIDTH  = 16;
  localparam int DEF_FILL_LATENCY = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_WAIT_TRI,
    ST_SWEEP,
    ST_DRAIN
  } seq_state_t;

endpackage

// File: rtl/raster_frame_sequencer_if.sv
// Triangle handshake, fill-unit coordinate/result and pixel BRAM port A.
interface raster_frame_sequencer_if #(
  parameter int COORD_BITS  = 16,
  parameter int ADDR_BITS   = 18,
  parameter int COLOR_WIDTH = 16
);
  logic                   tri_valid;
  logic                   tri_ready;
  logic [COLOR_WIDTH-1:0] tri_color;
  logic                   tri_last;
  logic [COORD_BITS-1:0]  hcount;
  logic [COORD_BITS-1:0]  vcount;
  logic                   coord_valid;
  logic                   is_within;
  logic                   is_within_valid;
  logic                   bram_we;
  logic [ADDR_BITS-1:0]   bram_addr;
  logic [COLOR_WIDTH-1:0] bram_din;

  modport master (
    input  tri_valid, tri_color, tri_last, is_within, is_within_valid,
    output tri_ready, hcount, vcount, coord_valid, bram_we, bram_addr, bram_din
  );

  modport slave (
    output tri_valid, tri_color, tri_last, is_within, is_within_valid,
    input  tri_ready, hcount, vcount, coord_valid, bram_we, bram_addr, bram_din
  );
endinterface

// File: rtl/pipe.sv
// Fixed-length register delay line, cleared on reset.
module pipe #(
  parameter int WIDTH  = 1,
  parameter int LENGTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);
  logic [WIDTH-1:0] r_stage [LENGTH];

  assign o_q = r_stage[LENGTH-1];

  // Shift one stage per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LENGTH; i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= i_d;
      for (int i = 1; i < LENGTH; i++) r_stage[i] <= r_stage[i-1];
    end
  end
endmodule

// File: rtl/raster_scan_counter.sv
// Raster-order x/y generator with a parallel linear address; x runs fastest.
module raster_scan_counter #(
  parameter int FRAME_WIDTH  = 512,
  parameter int FRAME_HEIGHT = 384,
  parameter int COORD_BITS   = 16,
  parameter int ADDR_BITS    = 18
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic                  i_enable,
  output logic [COORD_BITS-1:0] o_x,
  output logic [COORD_BITS-1:0] o_y,
  output logic [ADDR_BITS-1:0]  o_addr,
  output logic                  o_last
);
  localparam logic [COORD_BITS-1:0] X_MAX = COORD_BITS'(FRAME_WIDTH - 1);
  localparam logic [COORD_BITS-1:0] Y_MAX = COORD_BITS'(FRAME_HEIGHT - 1);

  logic [COORD_BITS-1:0] r_x;
  logic [COORD_BITS-1:0] r_y;
  logic [ADDR_BITS-1:0]  r_addr;
  logic                  w_last;

  assign w_last = (r_x == X_MAX) && (r_y == Y_MAX);
  assign o_x    = r_x;
  assign o_y    = r_y;
  assign o_addr = r_addr;
  assign o_last = w_last;

  // Advance one pixel per enabled cycle, wrapping to (0,0) after the last pixel.
  always_ff @(posedge clk) begin
    if (rst || i_start) begin
      r_x    <= '0;
      r_y    <= '0;
      r_addr <= '0;
    end else if (i_enable) begin
      if (r_x == X_MAX) begin
        r_x <= '0;
        r_y <= (r_y == Y_MAX) ? '0 : r_y + 1'b1;
      end else begin
        r_x <= r_x + 1'b1;
      end
      r_addr <= w_last ? '0 : r_addr + 1'b1;
    end
  end
endmodule

// File: rtl/raster_frame_sequencer.sv
// Frame sequencer: clears the framebuffer, then sweeps the screen once per
// accepted triangle and writes covered pixels returned by the fill unit.
//
//  state    | meaning
//  IDLE     | waiting for frame_start
//  CLEAR    | writing clear colour to every address, one per cycle
//  WAIT_TRI | tri_ready high, waiting for a triangle
//  SWEEP    | emitting raster coordinates to the fill unit
//  DRAIN    | letting in-flight fill results retire
module raster_frame_sequencer
  import raster_frame_sequencer_pkg::*;
#(
  parameter int FRAME_WIDTH  = DEF_FRAME_WIDTH,
  parameter int FRAME_HEIGHT = DEF_FRAME_HEIGHT,
  parameter int COORD_BITS   = DEF_COORD_BITS,
  parameter int ADDR_BITS    = DEF_ADDR_BITS,
  parameter int COLOR_WIDTH  = DEF_COLOR_WIDTH,
  parameter int FILL_LATENCY = DEF_FILL_LATENCY
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_frame_start,
  input  logic [COLOR_WIDTH-1:0] i_clear_color,
  output logic                   o_busy,
  output logic                   o_frame_done,
  raster_frame_sequencer_if.master bus
);
  localparam int DRAIN_W = $clog2(FILL_LATENCY + 1);

  seq_state_t             r_state, w_state_nxt;
  logic                   r_tri_ready;
  logic [COLOR_WIDTH-1:0] r_clear_color;
  logic [COLOR_WIDTH-1:0] r_tri_color;
  logic                   r_tri_last;
  logic [DRAIN_W-1:0]     r_drain_cnt;

  logic [COORD_BITS-1:0]  w_x, w_y;
  logic [ADDR_BITS-1:0]   w_addr;
  logic                   w_last;
  logic                   w_clear, w_sweep, w_tri_accept, w_frame_done;
  logic [ADDR_BITS:0]     w_dly;
  logic                   w_pix_we;

  assign w_clear      = (r_state == ST_CLEAR);
  assign w_sweep      = (r_state == ST_SWEEP);
  assign w_tri_accept = (r_state == ST_WAIT_TRI) && r_tri_ready && bus.tri_valid;

  raster_scan_counter #(
    .FRAME_WIDTH (FRAME_WIDTH),
    .FRAME_HEIGHT(FRAME_HEIGHT),
    .COORD_BITS  (COORD_BITS),
    .ADDR_BITS   (ADDR_BITS)
  ) u_scan (
    .clk     (clk),
    .rst     (rst),
    .i_start ((r_state == ST_IDLE) || (r_state == ST_WAIT_TRI)),
    .i_enable(w_clear || w_sweep),
    .o_x     (w_x),
    .o_y     (w_y),
    .o_addr  (w_addr),
    .o_last  (w_last)
  );

  // Linear address travels with the valid bit so no multiply is needed on write.
  pipe #(
    .WIDTH (ADDR_BITS + 1),
    .LENGTH(FILL_LATENCY)
  ) u_dly (
    .clk(clk),
    .rst(rst),
    .i_d({w_sweep, w_addr}),
    .o_q(w_dly)
  );

  assign w_pix_we = w_dly[ADDR_BITS] && bus.is_within_valid && bus.is_within;

  // Next-state decode.
  always_comb begin
    w_state_nxt  = r_state;
    w_frame_done = 1'b0;
    case (r_state)
      ST_IDLE:     if (i_frame_start) w_state_nxt = ST_CLEAR;
      ST_CLEAR:    if (w_last) w_state_nxt = ST_WAIT_TRI;
      ST_WAIT_TRI: if (w_tri_accept) w_state_nxt = ST_SWEEP;
      ST_SWEEP:    if (w_last) w_state_nxt = ST_DRAIN;
      ST_DRAIN: begin
        if (r_drain_cnt == '0) begin
          if (r_tri_last) begin
            w_frame_done = 1'b1;
            w_state_nxt  = ST_IDLE;
          end else begin
            w_state_nxt = ST_WAIT_TRI;
          end
        end
      end
      default:     w_state_nxt = ST_IDLE;
    endcase
  end

  // State register, registered ready and latched frame/triangle attributes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_tri_ready   <= 1'b0;
      r_clear_color <= '0;
      r_tri_color   <= '0;
      r_tri_last    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_tri_ready <= (w_state_nxt == ST_WAIT_TRI);
      if ((r_state == ST_IDLE) && i_frame_start) r_clear_color <= i_clear_color;
      if (w_tri_accept) begin
        r_tri_color <= bus.tri_color;
        r_tri_last  <= bus.tri_last;
      end
    end
  end

  // Drain timer: loaded while sweeping, counts down to terminal zero in DRAIN.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_drain_cnt <= '0;
    end else if (w_sweep) begin
      r_drain_cnt <= DRAIN_W'(FILL_LATENCY - 1);
    end else if ((r_state == ST_DRAIN) && (r_drain_cnt != '0)) begin
      r_drain_cnt <= r_drain_cnt - 1'b1;
    end
  end

  assign bus.tri_ready   = r_tri_ready;
  assign bus.coord_valid = w_sweep;
  assign bus.hcount      = w_sweep ? w_x : '0;
  assign bus.vcount      = w_sweep ? w_y : '0;
  assign bus.bram_we     = w_clear || w_pix_we;
  assign bus.bram_addr   = w_clear ? w_addr :
                           (w_pix_we ? w_dly[ADDR_BITS-1:0] : '0);
  assign bus.bram_din    = w_clear ? r_clear_color :
                           (w_pix_we ? r_tri_color : '0);
  assign o_busy          = (r_state != ST_IDLE);
  assign o_frame_done    = w_frame_done;
endmodule

// File: tb/tb_raster_frame_sequencer.sv
// Directed bench for raster_frame_sequencer on an 8x4 frame with a 4-cycle fill model.
module tb_raster_frame_sequencer;
  localparam int W  = 8;
  localparam int H  = 4;
  localparam int FL = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_start;
  logic [15:0] clear_color;
  logic        busy, frame_done;

  raster_frame_sequencer_if #(.COORD_BITS(16), .ADDR_BITS(5), .COLOR_WIDTH(16)) bus ();

  raster_frame_sequencer #(
    .FRAME_WIDTH(W), .FRAME_HEIGHT(H), .COORD_BITS(16),
    .ADDR_BITS(5), .COLOR_WIDTH(16), .FILL_LATENCY(FL)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_frame_start(frame_start),
    .i_clear_color(clear_color),
    .o_busy       (busy),
    .o_frame_done (frame_done),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  // Fill unit model: coverage chosen by cov_mode, FL cycles of latency.
  int       cov_mode;
  logic     force_w;
  logic [FL-1:0] fv, fw;

  function automatic logic covers(input logic [15:0] x, input logic [15:0] y, input int mode);
    case (mode)
      0: return x < 4;
      1: return 1'b1;
      2: return (x == 7) && (y == 3);
      default: return 1'b0;
    endcase
  endfunction

  always @(posedge clk) begin
    fv <= {fv[FL-2:0], bus.coord_valid};
    fw <= {fw[FL-2:0], covers(bus.hcount, bus.vcount, cov_mode)};
  end
  assign bus.is_within_valid = force_w ? 1'b1 : fv[FL-1];
  assign bus.is_within       = force_w ? 1'b1 : fw[FL-1];

  // Memory, write/coord/frame_done bookkeeping.
  logic [15:0] mem [W*H];
  int cyc, n_wr, n_coord, n_fd, lat_bad;
  int coord_cyc [W*H];
  logic lat_on;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (bus.bram_we) begin
      mem[bus.bram_addr] = bus.bram_din;
      n_wr = n_wr + 1;
      if (lat_on && (cyc - coord_cyc[bus.bram_addr] != FL)) lat_bad = lat_bad + 1;
    end
    if (bus.coord_valid) begin
      coord_cyc[bus.vcount*W + bus.hcount] = cyc;
      n_coord = n_coord + 1;
    end
    if (frame_done) n_fd = n_fd + 1;
  end

  int n_chk, n_pass;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic pulse_frame_start(input logic [15:0] c);
    frame_start = 1'b1;
    clear_color = c;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic wait_ready(input string tag, input int bound);
    int n;
    n = 0;
    while (!bus.tri_ready && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk(tag, bus.tri_ready, 1);
  endtask

  task automatic send_tri(input logic [15:0] c, input logic last, input int mode);
    cov_mode = mode;
    wait_ready("tri_ready_wait", 200);
    bus.tri_valid = 1'b1;
    bus.tri_color = c;
    bus.tri_last  = last;
    @(negedge clk);
    bus.tri_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int bound);
    int n;
    n = 0;
    while (busy && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk(tag, busy, 0);
  endtask

  task automatic two_tri_frame(input logic disturb);
    int wr0, fd0, n, errs;
    logic [15:0] e;
    wr0 = n_wr;
    fd0 = n_fd;
    pulse_frame_start(16'h0F0F);
    if (disturb) begin
      repeat (5) @(negedge clk);
      bus.tri_valid = 1'b1; bus.tri_color = 16'h00A0; bus.tri_last = 1'b1;
      @(negedge clk);
      bus.tri_valid = 1'b0;
    end
    send_tri(16'h0A00, 1'b0, 1);
    if (disturb) begin
      repeat (5) @(negedge clk);
      frame_start = 1'b1; clear_color = 16'hFFFF;
      @(negedge clk);
      frame_start = 1'b0;
    end
    n = 0;
    while (!bus.tri_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(disturb ? "dist_ready_low" : "two_ready_low", n, disturb ? 30 : 36);
    send_tri(16'h00A0, 1'b1, 2);
    wait_idle(disturb ? "dist_idle" : "two_idle", 100);
    chk(disturb ? "dist_writes" : "two_writes", n_wr - wr0, 65);
    chk(disturb ? "dist_fd" : "two_fd", n_fd - fd0, 1);
    errs = 0;
    for (int a = 0; a < W*H; a++) begin
      e = (a == 31) ? 16'h00A0 : 16'h0A00;
      if (mem[a] !== e) errs++;
    end
    chk(disturb ? "dist_mem" : "two_mem", errs, 0);
  endtask

  initial begin
    int errs, wr0, fd0, cv0, n;
    logic [15:0] e;
    cyc = 0; n_wr = 0; n_coord = 0; n_fd = 0; lat_bad = 0; lat_on = 1'b0;
    n_chk = 0; n_pass = 0;
    rst = 1'b1; frame_start = 1'b0; clear_color = '0;
    bus.tri_valid = 1'b0; bus.tri_color = '0; bus.tri_last = 1'b0;
    cov_mode = 3; force_w = 1'b0;
    repeat (6) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_we", bus.bram_we, 0);
    chk("rst_ready", bus.tri_ready, 0);
    chk("rst_cv", bus.coord_valid, 0);
    chk("rst_fd", frame_done, 0);
    rst = 1'b0;
    @(negedge clk);

    // Clear: 32 consecutive writes of 0F0F, ready the cycle after.
    pulse_frame_start(16'h0F0F);
    errs = 0;
    for (int i = 0; i < W*H; i++) begin
      if (!(bus.bram_we && bus.bram_addr == 5'(i) && bus.bram_din == 16'h0F0F && busy)) errs++;
      @(negedge clk);
    end
    chk("clr_seq", errs, 0);
    chk("clr_ready_after", bus.tri_ready, 1);
    chk("clr_we_after", bus.bram_we, 0);

    // One triangle covering x<4.
    wr0 = n_wr; fd0 = n_fd; cv0 = n_coord; lat_bad = 0; lat_on = 1'b1;
    send_tri(16'h0F00, 1'b1, 0);
    wait_idle("t1_idle", 100);
    lat_on = 1'b0;
    chk("t1_writes", n_wr - wr0, 16);
    chk("t1_latency", lat_bad, 0);
    chk("t1_coords", n_coord - cv0, 32);
    chk("t1_fd", n_fd - fd0, 1);
    errs = 0;
    for (int a = 0; a < W*H; a++) begin
      e = ((a % W) < 4) ? 16'h0F00 : 16'h0F0F;
      if (mem[a] !== e) errs++;
    end
    chk("t1_mem", errs, 0);

    // Two triangles, clean and with ignored stray frame_start / tri_valid.
    two_tri_frame(1'b0);
    two_tri_frame(1'b1);

    // Reset mid-sweep at (3,2).
    pulse_frame_start(16'h0F0F);
    send_tri(16'h0A00, 1'b1, 1);
    n = 0;
    while (!(bus.coord_valid && bus.hcount == 3 && bus.vcount == 2) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("abort_coord_seen", bus.coord_valid && bus.hcount == 3 && bus.vcount == 2, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_we", bus.bram_we, 0);
    chk("abort_cv", bus.coord_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_ready", bus.tri_ready, 0);
    chk("abort_fd", frame_done, 0);
    wr0 = n_wr; fd0 = n_fd;
    @(negedge clk);
    rst = 1'b0;
    force_w = 1'b1;
    repeat (8) @(negedge clk);
    force_w = 1'b0;
    chk("idle_force_writes", n_wr - wr0, 0);
    chk("abort_no_fd", n_fd - fd0, 0);

    // Restart begins at clear address 0.
    pulse_frame_start(16'h1234);
    chk("restart_we", bus.bram_we, 1);
    chk("restart_addr", bus.bram_addr, 0);
    chk("restart_din", bus.bram_din, 16'h1234);
    wait_ready("restart_ready", 100);
    wr0 = n_wr;
    force_w = 1'b1;
    repeat (8) @(negedge clk);
    force_w = 1'b0;
    chk("wait_force_writes", n_wr - wr0, 0);
    chk("wait_still_ready", bus.tri_ready, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
